// File: rtl/univ_sr_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : univ_sr_pkg
// Description : Shared encodings for the universal shift register: shift
//               direction codes and the command FSM state type.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package univ_sr_pkg;

    // Shift direction encodings, shared by the free-run and command paths
    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_SHL  = 2'b01;
    localparam logic [1:0] DIR_SHR  = 2'b10;
    localparam logic [1:0] DIR_ROL  = 2'b11;

    // Command sequencer states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : univ_sr_pkg
`default_nettype wire

// File: rtl/univ_shift_reg_shift_step.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : shift_step
// Description : Combinational single-step shifter. Computes the next register
//               value and the bit leaving the register for one step in the
//               requested direction.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module shift_step
    import univ_sr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [1:0]       dir,
    input  logic             ser_in,
    input  logic             arith,
    output logic [WIDTH-1:0] nxt,
    output logic             out_bit
);

    logic w_fill;

    // Right shifts either sign-extend or take the serial fill bit
    assign w_fill = arith ? cur[WIDTH-1] : ser_in;

    // One step of shift/rotate; hold leaves the value untouched and reports 0
    // (the caller does not update its serial-out register on a hold step)
    always_comb begin
        nxt     = cur;
        out_bit = 1'b0;
        case (dir)
            DIR_SHL: begin
                nxt     = {cur[WIDTH-2:0], ser_in};
                out_bit = cur[WIDTH-1];
            end
            DIR_SHR: begin
                nxt     = {w_fill, cur[WIDTH-1:1]};
                out_bit = cur[0];
            end
            DIR_ROL: begin
                nxt     = {cur[WIDTH-2:0], cur[WIDTH-1]};
                out_bit = cur[WIDTH-1];
            end
            default: begin
                nxt     = cur;
                out_bit = 1'b0;
            end
        endcase
    end

endmodule : shift_step
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : univ_shift_reg
// Description : Parametrised universal shift register with parallel load,
//               free-running shift/rotate and an N-step command port with a
//               valid/ready handshake and a one-cycle done pulse.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module univ_shift_reg
    import univ_sr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [1:0]       dir,
    input  logic             ser_in,
    input  logic             arith,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_dir,
    input  logic [CNT_W-1:0] cmd_amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             ser_out
);

    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(WIDTH);

    state_t           r_state_q, w_state_d;
    logic [WIDTH-1:0] r_out_q,   w_out_d;
    logic             r_ser_q,   w_ser_d;
    logic [CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic [1:0]       r_cdir_q,  w_cdir_d;
    logic             r_done_q,  w_done_d;

    logic             w_take_step;
    logic [1:0]       w_step_dir;
    logic [WIDTH-1:0] w_step_nxt;
    logic             w_step_bit;
    logic [CNT_W-1:0] w_amount_clamped;

    // A load in the same cycle blocks command acceptance
    assign cmd_ready = (r_state_q == ST_IDLE) && !load;
    assign busy      = (r_state_q == ST_RUN);
    assign done      = r_done_q;
    assign out       = r_out_q;
    assign ser_out   = r_ser_q;

    // While a command runs the latched command direction drives the shifter
    assign w_step_dir       = (r_state_q == ST_RUN) ? r_cdir_q : dir;
    assign w_amount_clamped = (cmd_amount > c_max_cnt) ? c_max_cnt : cmd_amount;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .cur     (r_out_q),
        .dir     (w_step_dir),
        .ser_in  (ser_in),
        .arith   (arith),
        .nxt     (w_step_nxt),
        .out_bit (w_step_bit)
    );

    // Next-state logic: load / accept / free-run priority in IDLE, counted steps in RUN
    always_comb begin
        w_state_d   = r_state_q;
        w_out_d     = r_out_q;
        w_ser_d     = r_ser_q;
        w_cnt_d     = r_cnt_q;
        w_cdir_d    = r_cdir_q;
        w_done_d    = 1'b0;
        w_take_step = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (load) begin
                    w_out_d = load_data;
                end else if (cmd_valid && cmd_ready) begin
                    w_cdir_d  = cmd_dir;
                    w_cnt_d   = w_amount_clamped;
                    w_state_d = ST_RUN;
                end else if (en) begin
                    w_take_step = 1'b1;
                end
            end
            ST_RUN: begin
                if (en) begin
                    // A zero-length command finishes without shifting
                    if (r_cnt_q != '0) begin
                        w_take_step = 1'b1;
                        w_cnt_d     = r_cnt_q - 1'b1;
                    end
                    if (r_cnt_q <= CNT_W'(1)) begin
                        w_state_d = ST_IDLE;
                        w_done_d  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        if (w_take_step) begin
            w_out_d = w_step_nxt;
            if (w_step_dir != DIR_HOLD) begin
                w_ser_d = w_step_bit;
            end
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state_q <= ST_IDLE;
            r_out_q   <= '0;
            r_ser_q   <= 1'b0;
            r_cnt_q   <= '0;
            r_cdir_q  <= DIR_HOLD;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_out_q   <= w_out_d;
            r_ser_q   <= w_ser_d;
            r_cnt_q   <= w_cnt_d;
            r_cdir_q  <= w_cdir_d;
            r_done_q  <= w_done_d;
        end
    end

endmodule : univ_shift_reg
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_univ_shift_reg
// Description : Self-checking bench for univ_shift_reg. Stimulus pushes the
//               reference model's expected outputs into a queue; a monitor
//               pops and compares after every clock edge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             en = 1'b0;
    logic [1:0]       dir = 2'b00;
    logic             ser_in = 1'b0;
    logic             arith = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_data = '0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_dir = 2'b00;
    logic [CNT_W-1:0] cmd_amount = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             ser_out;

    univ_shift_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .dir        (dir),
        .ser_in     (ser_in),
        .arith      (arith),
        .load       (load),
        .load_data  (load_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_dir    (cmd_dir),
        .cmd_amount (cmd_amount),
        .busy       (busy),
        .done       (done),
        .out        (out),
        .ser_out    (ser_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   out;
        logic ser;
        logic done;
        logic busy;
        logic ready;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: register value as an integer, pending command as a
    // queue of step directions (-1 marks a zero-length command)
    int   m_out = 0;
    logic m_ser = 1'b0;
    logic m_done = 1'b0;
    int   m_steps[$];

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_step(input int d, input logic s, input logic a);
        int fill;
        case (d)
            1: begin
                m_ser = logic'((m_out / 128) % 2);
                m_out = (m_out * 2 + int'(s)) % 256;
            end
            2: begin
                fill  = a ? (m_out / 128) % 2 : int'(s);
                m_ser = logic'(m_out % 2);
                m_out = m_out / 2 + fill * 128;
            end
            3: begin
                m_ser = logic'(m_out / 128);
                m_out = (m_out * 2) % 256 + m_out / 128;
            end
            default: ;
        endcase
    endtask

    // Apply inputs at the falling edge, predict the next rising edge's result
    task automatic drv(input logic e, input logic [1:0] d, input logic s, input logic a,
                       input logic ld, input logic [7:0] ldd, input logic cv,
                       input logic [1:0] cd, input logic [3:0] ca);
        exp_t x;
        int   n;
        @(negedge clk);
        rstn = 1'b1; en = e; dir = d; ser_in = s; arith = a;
        load = ld; load_data = ldd; cmd_valid = cv; cmd_dir = cd; cmd_amount = ca;
        #1;
        chk("cmd_ready_comb", int'(cmd_ready), int'((m_steps.size() == 0) && !ld));
        m_done = 1'b0;
        if (m_steps.size() == 0) begin
            if (ld) begin
                m_out = int'(ldd);
            end else if (cv) begin
                n = (int'(ca) > WIDTH) ? WIDTH : int'(ca);
                if (n == 0) m_steps.push_back(-1);
                for (int i = 0; i < n; i++) m_steps.push_back(int'(cd));
            end else if (e) begin
                model_step(int'(d), s, a);
            end
        end else if (e) begin
            n = m_steps.pop_front();
            if (n >= 0) model_step(n, s, a);
            if (m_steps.size() == 0) m_done = 1'b1;
        end
        x.out   = m_out;
        x.ser   = m_ser;
        x.done  = m_done;
        x.busy  = (m_steps.size() != 0);
        x.ready = (m_steps.size() == 0) && !ld;
        exp_q.push_back(x);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        rstn = 1'b0; load = 1'b0; cmd_valid = 1'b0;
        #1;
        m_out = 0; m_ser = 1'b0; m_done = 1'b0; m_steps.delete();
        chk("reset_out", int'(out), m_out);
        chk("reset_ser", int'(ser_out), int'(m_ser));
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
    endtask

    // Monitor: compare registered outputs just after each active edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (rstn) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    x = exp_q.pop_front();
                    chk("out", int'(out), x.out);
                    chk("ser_out", int'(ser_out), int'(x.ser));
                    chk("done", int'(done), int'(x.done));
                    chk("busy", int'(busy), int'(x.busy));
                    chk("cmd_ready", int'(cmd_ready), int'(x.ready));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_pulse();
        // Load then shift left three times
        drv(0, 2'b00, 0, 0, 1, 8'h81, 0, 2'b00, 4'd0);
        repeat (3) drv(1, 2'b01, 0, 0, 0, 8'h00, 0, 2'b00, 4'd0);
        // Arithmetic and logical right shifts
        drv(0, 2'b00, 0, 0, 1, 8'h81, 0, 2'b00, 4'd0);
        repeat (2) drv(1, 2'b10, 0, 1, 0, 8'h00, 0, 2'b00, 4'd0);
        drv(0, 2'b00, 0, 0, 1, 8'h81, 0, 2'b00, 4'd0);
        repeat (2) drv(1, 2'b10, 0, 0, 0, 8'h00, 0, 2'b00, 4'd0);
        // Full rotation
        drv(0, 2'b00, 0, 0, 1, 8'h81, 0, 2'b00, 4'd0);
        repeat (8) drv(1, 2'b11, 0, 0, 0, 8'h00, 0, 2'b00, 4'd0);
        // Command of 3 left steps with en dropped two cycles and a load during RUN
        drv(0, 2'b00, 0, 0, 1, 8'h01, 0, 2'b00, 4'd0);
        drv(1, 2'b00, 0, 0, 0, 8'h00, 1, 2'b01, 4'd3);
        drv(1, 2'b10, 1, 0, 0, 8'h00, 0, 2'b00, 4'd0);
        drv(0, 2'b10, 1, 0, 1, 8'hFF, 0, 2'b00, 4'd0);
        drv(0, 2'b10, 0, 0, 0, 8'h00, 1, 2'b11, 4'd2);
        drv(1, 2'b00, 0, 0, 0, 8'h00, 0, 2'b00, 4'd0);
        drv(1, 2'b00, 0, 0, 0, 8'h00, 0, 2'b00, 4'd0);
        drv(0, 2'b00, 0, 0, 0, 8'h00, 0, 2'b00, 4'd0);
        // Zero-length command
        drv(1, 2'b00, 0, 0, 0, 8'h00, 1, 2'b01, 4'd0);
        drv(0, 2'b00, 0, 0, 0, 8'h00, 0, 2'b00, 4'd0);
        // Load and command in the same cycle: load wins
        drv(1, 2'b01, 1, 0, 1, 8'h5A, 1, 2'b01, 4'd2);
        drv(0, 2'b00, 0, 0, 0, 8'h00, 0, 2'b00, 4'd0);
        // Clamped command amount
        drv(1, 2'b00, 0, 0, 0, 8'h00, 1, 2'b11, 4'd15);
        repeat (9) drv(1, 2'b01, 1, 0, 0, 8'h00, 0, 2'b00, 4'd0);
        // Reset in the middle of a command
        drv(1, 2'b00, 0, 0, 1, 8'hC3, 0, 2'b00, 4'd0);
        drv(1, 2'b00, 0, 0, 0, 8'h00, 1, 2'b01, 4'd5);
        drv(1, 2'b00, 0, 0, 0, 8'h00, 0, 2'b00, 4'd0);
        rst_pulse();
        drv(0, 2'b00, 0, 0, 0, 8'h00, 0, 2'b00, 4'd0);
        drv(0, 2'b00, 0, 0, 0, 8'h00, 0, 2'b00, 4'd0);
        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) rst_pulse();
            drv(logic'($urandom_range(0, 9) < 8), 2'($urandom), 1'($urandom), 1'($urandom),
                logic'($urandom_range(0, 9) == 0), 8'($urandom),
                logic'($urandom_range(0, 3) == 0), 2'($urandom), 4'($urandom));
        end
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_univ_shift_reg
`default_nettype wire
